// File: rtl/bus_slave_port_pkg.sv
// Shared definitions for the bit-serial bus: frame mode values, default field widths
// and the slave-port FSM encoding.
package bus_slave_port_pkg;

    localparam int DEF_ADDR_WIDTH = 12;
    localparam int DEF_DATA_WIDTH = 8;

    localparam logic MODE_WRITE = 1'b1;
    localparam logic MODE_READ  = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WDATA,
        ST_MEM_WR,
        ST_MEM_RD,
        ST_WAIT_RD,
        ST_RDATA
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bus_slave_port_if.sv
// Per-slave view of the bit-serial bus as routed by the arbiter's slave mux.
interface bus_slave_port_if;

    logic slave_select;
    logic bus_in;
    logic bus_in_v;
    logic slave_dout;
    logic slave_dout_v;
    logic slave_ack;
    logic slave_err;
    logic slave_busy;

    modport master (
        output slave_select, bus_in, bus_in_v,
        input  slave_dout, slave_dout_v, slave_ack, slave_err, slave_busy
    );

    modport slave (
        input  slave_select, bus_in, bus_in_v,
        output slave_dout, slave_dout_v, slave_ack, slave_err, slave_busy
    );

endinterface

// File: rtl/bus_slave_port_shift_reg.sv
// LSB-first shift register: serial bits enter at the MSB and move toward bit 0,
// so bit 0 is both the first bit received and the next bit transmitted.
module bus_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] shifted;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (gi == WIDTH - 1) begin : g_top
                assign shifted[gi] = ser_in;
            end else begin : g_low
                assign shifted[gi] = q_reg[gi+1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q_reg <= '0;
        end else if (load) begin
            q_reg <= load_data;
        end else if (shift) begin
            q_reg <= shifted;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/bus_slave_port.sv
// Responder end of the bit-serial bus: deserialises mode/address/write-data frames,
// strobes the local memory port and serialises read data back to the master.
module bus_slave_port
    import bus_slave_port_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int RD_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rstn,
    bus_slave_port_if.slave       bus,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rvalid
);

    localparam int CNT_W = $clog2(max_int(ADDR_WIDTH, DATA_WIDTH)) + 1;
    localparam int TMO_W = $clog2(RD_TIMEOUT + 1);

    state_t           state_reg;
    logic             mode_reg;
    logic [CNT_W-1:0] bit_cnt_reg;
    logic [TMO_W-1:0] tmo_cnt_reg;
    logic             busy_reg;
    logic             ack_reg;
    logic             err_reg;
    logic             we_reg;
    logic             re_reg;
    logic             dout_v_reg;

    logic                  sample;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rd_q;
    logic                  unused_rd_upper;

    assign sample = bus.slave_select & bus.bus_in_v;

    // Address and write-data registers only move during their own field, so they
    // also serve as the holding registers behind mem_addr/mem_wdata.
    bus_shift_reg #(.WIDTH(ADDR_WIDTH)) u_addr_sr (
        .clk       (clk),
        .rstn      (rstn),
        .load      (1'b0),
        .load_data ('0),
        .shift     ((state_reg == ST_ADDR) & sample),
        .ser_in    (bus.bus_in),
        .q         (addr_q)
    );

    bus_shift_reg #(.WIDTH(DATA_WIDTH)) u_wdata_sr (
        .clk       (clk),
        .rstn      (rstn),
        .load      (1'b0),
        .load_data ('0),
        .shift     ((state_reg == ST_WDATA) & sample),
        .ser_in    (bus.bus_in),
        .q         (wdata_q)
    );

    bus_shift_reg #(.WIDTH(DATA_WIDTH)) u_rdata_sr (
        .clk       (clk),
        .rstn      (rstn),
        .load      ((state_reg == ST_WAIT_RD) & mem_rvalid),
        .load_data (mem_rdata),
        .shift     (state_reg == ST_RDATA),
        .ser_in    (1'b0),
        .q         (rd_q)
    );

    assign unused_rd_upper = ^rd_q[DATA_WIDTH-1:1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg   <= ST_IDLE;
            mode_reg    <= MODE_READ;
            bit_cnt_reg <= '0;
            tmo_cnt_reg <= '0;
            busy_reg    <= 1'b0;
            ack_reg     <= 1'b0;
            err_reg     <= 1'b0;
            we_reg      <= 1'b0;
            re_reg      <= 1'b0;
            dout_v_reg  <= 1'b0;
        end else begin
            ack_reg <= 1'b0;
            err_reg <= 1'b0;
            we_reg  <= 1'b0;
            re_reg  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (sample) begin
                        mode_reg    <= bus.bus_in;
                        bit_cnt_reg <= '0;
                        busy_reg    <= 1'b1;
                        state_reg   <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (!bus.slave_select) begin
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end else if (bus.bus_in_v) begin
                        if (bit_cnt_reg == CNT_W'(ADDR_WIDTH - 1)) begin
                            bit_cnt_reg <= '0;
                            if (mode_reg == MODE_READ) begin
                                re_reg    <= 1'b1;
                                state_reg <= ST_MEM_RD;
                            end else begin
                                state_reg <= ST_WDATA;
                            end
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                        end
                    end
                end
                ST_WDATA: begin
                    if (!bus.slave_select) begin
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end else if (bus.bus_in_v) begin
                        if (bit_cnt_reg == CNT_W'(DATA_WIDTH - 1)) begin
                            we_reg    <= 1'b1;
                            ack_reg   <= 1'b1;
                            state_reg <= ST_MEM_WR;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                        end
                    end
                end
                ST_MEM_WR: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                ST_MEM_RD: begin
                    // The mem_re cycle itself counts toward the timeout budget.
                    tmo_cnt_reg <= TMO_W'(1);
                    if (RD_TIMEOUT == 1) begin
                        err_reg   <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end else begin
                        state_reg <= ST_WAIT_RD;
                    end
                end
                ST_WAIT_RD: begin
                    if (mem_rvalid) begin
                        bit_cnt_reg <= '0;
                        dout_v_reg  <= 1'b1;
                        state_reg   <= ST_RDATA;
                    end else if (tmo_cnt_reg == TMO_W'(RD_TIMEOUT - 1)) begin
                        err_reg   <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
                    end
                end
                ST_RDATA: begin
                    if (bit_cnt_reg == CNT_W'(DATA_WIDTH - 1)) begin
                        dout_v_reg <= 1'b0;
                        busy_reg   <= 1'b0;
                        state_reg  <= ST_IDLE;
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    dout_v_reg <= 1'b0;
                    busy_reg   <= 1'b0;
                    state_reg  <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_addr         = addr_q;
    assign mem_wdata        = wdata_q;
    assign mem_we           = we_reg;
    assign mem_re           = re_reg;
    assign bus.slave_dout   = rd_q[0];
    assign bus.slave_dout_v = dout_v_reg;
    assign bus.slave_ack    = ack_reg;
    assign bus.slave_err    = err_reg;
    assign bus.slave_busy   = busy_reg;

endmodule

// File: tb/tb_bus_slave_port.sv
// Directed bench for bus_slave_port: writes, reads, gaps, aborts, timeout and mid-frame reset.
module tb_bus_slave_port;
    import bus_slave_port_pkg::*;

    localparam int AW = 12;
    localparam int DW = 8;
    localparam int RT = 15;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    bus_slave_port_if bus_if ();

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic          mem_re;
    logic [DW-1:0] mem_rdata;
    logic          mem_rvalid;

    bus_slave_port #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RD_TIMEOUT (RT)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .bus        (bus_if),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Strobe-cycle counters, sampled mid-cycle.
    int we_cyc  = 0;
    int re_cyc  = 0;
    int err_cyc = 0;
    int dv_cyc  = 0;
    always @(negedge clk) begin
        if (mem_we) we_cyc++;
        if (mem_re) re_cyc++;
        if (bus_if.slave_err) err_cyc++;
        if (bus_if.slave_dout_v) dv_cyc++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({mem_addr, mem_wdata, mem_we, mem_re, bus_if.slave_dout,
                    bus_if.slave_dout_v, bus_if.slave_ack, bus_if.slave_err, bus_if.slave_busy});
    endfunction

    task automatic send_bit(input logic b);
        @(negedge clk);
        bus_if.slave_select = 1'b1;
        bus_if.bus_in       = b;
        bus_if.bus_in_v     = 1'b1;
    endtask

    task automatic gap_bit(input logic b);
        @(negedge clk);
        bus_if.bus_in   = ~b;
        bus_if.bus_in_v = 1'b0;
    endtask

    task automatic send_frame(input logic mode, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input bit gaps);
        send_bit(mode);
        for (int i = 0; i < AW; i++) begin
            if (gaps) gap_bit(a[i]);
            send_bit(a[i]);
        end
        if (mode == MODE_WRITE) begin
            for (int i = 0; i < DW; i++) begin
                if (gaps) gap_bit(d[i]);
                send_bit(d[i]);
            end
        end
    endtask

    task automatic end_frame();
        @(negedge clk);
        bus_if.bus_in_v = 1'b0;
        bus_if.bus_in   = 1'b0;
    endtask

    task automatic do_write(input string tag, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input bit gaps);
        int we0;
        we0 = we_cyc;
        send_frame(MODE_WRITE, a, d, gaps);
        end_frame();
        check({tag, ".we_ack_re"}, 32'({mem_we, bus_if.slave_ack, mem_re}), 32'(3'b110));
        check({tag, ".addr"}, 32'(mem_addr), 32'(a));
        check({tag, ".data"}, 32'(mem_wdata), 32'(d));
        check({tag, ".busy"}, 32'(bus_if.slave_busy), 32'(1));
        @(negedge clk);
        check({tag, ".after"}, 32'({mem_we, bus_if.slave_ack, bus_if.slave_busy}), 32'(0));
        check({tag, ".hold"}, 32'({mem_addr, mem_wdata}), 32'({a, d}));
        check({tag, ".we_cycles"}, we_cyc - we0, 1);
        $display("txn %s write addr=0x%03h data=0x%02h gaps=%0d", tag, a, d, gaps);
    endtask

    task automatic do_read(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int dly, input int rst_at);
        int re0;
        int dv0;
        re0 = re_cyc;
        dv0 = dv_cyc;
        send_frame(MODE_READ, a, '0, 1'b0);
        end_frame();
        check({tag, ".re_we"}, 32'({mem_re, mem_we}), 32'(2'b10));
        check({tag, ".addr"}, 32'(mem_addr), 32'(a));
        repeat (dly) @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = d;
        for (int i = 0; i < DW; i++) begin
            @(negedge clk);
            if (i == 0) begin
                mem_rvalid = 1'b0;
                mem_rdata  = ~d;
            end
            check({tag, ".bit"}, 32'({bus_if.slave_dout_v, bus_if.slave_dout}), 32'({1'b1, d[i]}));
            if (i == rst_at) begin
                rstn = 1'b0;
                #1;
                check({tag, ".async_rst"}, all_outs(), 32'(0));
                $display("txn %s read addr=0x%03h reset at bit %0d", tag, a, i);
                return;
            end
        end
        @(negedge clk);
        check({tag, ".end"}, 32'({bus_if.slave_dout_v, bus_if.slave_busy}), 32'(0));
        check({tag, ".re_cycles"}, re_cyc - re0, 1);
        check({tag, ".dv_cycles"}, dv_cyc - dv0, DW);
        $display("txn %s read addr=0x%03h data=0x%02h", tag, a, d);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int we0;
        int re0;
        int err0;
        int dv0;
        int err_at;

        bus_if.slave_select = 1'b0;
        bus_if.bus_in       = 1'b0;
        bus_if.bus_in_v     = 1'b0;
        mem_rdata           = '0;
        mem_rvalid          = 1'b0;

        repeat (3) @(negedge clk);
        check("reset.outs", all_outs(), 32'(0));
        rstn = 1'b1;
        @(negedge clk);
        check("idle.outs", all_outs(), 32'(0));

        do_write("wr_nogap", 12'h123, 8'hA5, 1'b0);
        do_read("rd_3c", 12'h07F, 8'h3C, 3, -1);
        do_write("wr_gap", 12'h123, 8'hA5, 1'b1);

        // Abort: drop slave_select after the mode bit and five address bits.
        we0 = we_cyc;
        re0 = re_cyc;
        send_bit(MODE_WRITE);
        for (int i = 0; i < 5; i++) send_bit(i[0]);
        @(negedge clk);
        bus_if.slave_select = 1'b0;
        bus_if.bus_in_v     = 1'b1;
        check("abort.busy_before", 32'(bus_if.slave_busy), 32'(1));
        @(negedge clk);
        check("abort.busy_after", 32'(bus_if.slave_busy), 32'(0));
        repeat (4) @(negedge clk);
        bus_if.bus_in_v = 1'b0;
        check("abort.no_strobes", (we_cyc - we0) + (re_cyc - re0), 0);
        check("abort.idle", 32'({bus_if.slave_busy, bus_if.slave_ack}), 32'(0));
        $display("txn abort after 5 addr bits");
        do_write("wr_after_abort", 12'h2B6, 8'h4D, 1'b0);

        // Read with no response: error exactly RT cycles after mem_re.
        err0 = err_cyc;
        dv0  = dv_cyc;
        send_frame(MODE_READ, 12'h456, '0, 1'b0);
        end_frame();
        check("tmo.re", 32'(mem_re), 32'(1));
        err_at = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus_if.slave_err) begin
                err_at = k;
                break;
            end
        end
        check("tmo.err_delay", err_at, RT);
        @(negedge clk);
        check("tmo.err_drop", 32'({bus_if.slave_err, bus_if.slave_busy}), 32'(0));
        check("tmo.err_cycles", err_cyc - err0, 1);
        check("tmo.no_dout", dv_cyc - dv0, 0);
        $display("txn timeout read addr=0x456 err after %0d cycles", err_at);

        // Reset during read-data bit 3, then a fresh write.
        do_read("rd_rst", 12'h07F, 8'hFF, 1, 3);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("rst_release.outs", all_outs(), 32'(0));
        do_write("wr_after_rst", 12'h321, 8'h96, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
